// File: rtl/mips_pkg.sv
// Shared MIPS control-flow definitions: jump/branch mode encodings and the
// instruction size used when forming link addresses.
package mips_pkg;

    typedef enum logic [2:0] {
        MODE_NONE = 3'b000,
        MODE_J    = 3'b001,
        MODE_JAL  = 3'b010,
        MODE_BR   = 3'b011,
        MODE_JR   = 3'b100,
        MODE_JALR = 3'b101
    } mode_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a simultaneous push+pop replaces the top (or pushes if empty).
module ras_stack #(
    parameter int NBITS     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [NBITS-1:0] i_push_data,
    output logic [NBITS-1:0] o_top,
    output logic             o_empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);

    logic [NBITS-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q;
    logic [PW:0]      cnt_q;
    logic [PW-1:0]    top_idx;

    // sp_q is the next free slot; the top lives one below it, modulo depth.
    assign top_idx = sp_q - PTR_ONE;
    assign o_top   = mem_q[top_idx];
    assign o_empty = (cnt_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: entries are cleared on reset so a pop after reset reads a defined zero; this costs a reset net per storage bit.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (i_push && i_pop && !o_empty) begin
            mem_q[top_idx] <= i_push_data;
        end else if (i_push) begin
            mem_q[sp_q] <= i_push_data;
            sp_q        <= sp_q + PTR_ONE;
            if (cnt_q != CNT_FULL) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end else if (i_pop && !o_empty) begin
            sp_q  <= top_idx;
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/jump_target_ras.sv
// Jump/branch target unit with a return-address stack; one registered cycle
// from accepted operands to target, link and RAS prediction outputs.
module jump_target_ras
    import mips_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NBITSJUMP = 26,
    parameter int NBITSIMM  = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [2:0]           i_mode,
    input  logic [NBITS-1:0]     i_pc4,
    input  logic [NBITSJUMP-1:0] i_instr_index,
    input  logic [NBITSIMM-1:0]  i_imm,
    input  logic                 i_br_cond,
    input  logic [NBITS-1:0]     i_rs_data,
    input  logic                 i_rs_is_ra,
    output logic                 o_valid,
    output logic                 o_taken,
    output logic [NBITS-1:0]     o_target,
    output logic [NBITS-1:0]     o_link,
    output logic [NBITS-1:0]     o_ras_pred,
    output logic                 o_ras_hit
);

    logic [NBITS-1:0] jump_tgt, br_tgt, pc8;
    logic [NBITS-1:0] target_d, link_d, pred_d;
    logic             taken_d, hit_d, is_push, is_ret;
    logic             accepted, do_push, do_pop;
    logic [NBITS-1:0] ras_top;
    logic             ras_empty;

    logic             valid_q, taken_q, hit_q;
    logic [NBITS-1:0] target_q, link_q, pred_q;

    assign jump_tgt = {i_pc4[NBITS-1:NBITSJUMP+2], i_instr_index, 2'b00};
    assign br_tgt   = i_pc4 + {{(NBITS-NBITSIMM-2){i_imm[NBITSIMM-1]}}, i_imm, 2'b00};
    assign pc8      = i_pc4 + NBITS'(INSTR_BYTES);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        target_d = '0;
        link_d   = '0;
        taken_d  = 1'b0;
        is_push  = 1'b0;
        is_ret   = 1'b0;
        case (i_mode)
            MODE_J: begin
                target_d = jump_tgt;
                taken_d  = 1'b1;
            end
            MODE_JAL: begin
                target_d = jump_tgt;
                taken_d  = 1'b1;
                link_d   = pc8;
                is_push  = 1'b1;
            end
            MODE_BR: begin
                target_d = br_tgt;
                taken_d  = i_br_cond;
            end
            MODE_JR: begin
                target_d = i_rs_data;
                taken_d  = 1'b1;
                is_ret   = 1'b1;
            end
            MODE_JALR: begin
                target_d = i_rs_data;
                taken_d  = 1'b1;
                link_d   = pc8;
                is_push  = 1'b1;
                is_ret   = 1'b1;
            end
            default: ;
        endcase
    end

    assign accepted = i_valid && !i_stall && !i_flush;
    assign do_push  = accepted && is_push;
    assign do_pop   = accepted && is_ret && i_rs_is_ra;
    assign pred_d   = (do_pop && !ras_empty) ? ras_top : '0;
    assign hit_d    = do_pop && !ras_empty && (ras_top == i_rs_data);

    ras_stack #(
        .NBITS    (NBITS),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (do_push),
        .i_pop      (do_pop),
        .i_push_data(link_d),
        .o_top      (ras_top),
        .o_empty    (ras_empty)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values, matching the hardware.
        if (i_reset || i_flush) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
            pred_q   <= '0;
            hit_q    <= 1'b0;
        end else if (!i_stall) begin
            valid_q  <= i_valid;
            taken_q  <= taken_d;
            target_q <= target_d;
            link_q   <= link_d;
            pred_q   <= pred_d;
            hit_q    <= hit_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_taken    = taken_q;
    assign o_target   = target_q;
    assign o_link     = link_q;
    assign o_ras_pred = pred_q;
    assign o_ras_hit  = hit_q;

endmodule

// File: tb/tb_jump_target_ras.sv
// Self-checking bench for jump_target_ras: directed scenarios plus randomized
// traffic compared against a queue-based model of the target/RAS rules.
module tb_jump_target_ras;

    localparam int RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush, cond, rs_is_ra;
    logic [2:0]  mode;
    logic [31:0] pc4, rs_data;
    logic [25:0] idx;
    logic [15:0] imm;
    logic        o_valid, o_taken, o_ras_hit;
    logic [31:0] o_target, o_link, o_ras_pred;

    int n_tests = 0;
    int n_fail  = 0;

    logic        e_valid, e_taken, e_hit;
    logic [31:0] e_target, e_link, e_pred;
    logic [31:0] ras_m[$];

    always #5 clk = ~clk;

    jump_target_ras #(
        .NBITS(32), .NBITSJUMP(26), .NBITSIMM(16), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_mode(mode), .i_pc4(pc4), .i_instr_index(idx), .i_imm(imm),
        .i_br_cond(cond), .i_rs_data(rs_data), .i_rs_is_ra(rs_is_ra),
        .o_valid(o_valid), .o_taken(o_taken), .o_target(o_target), .o_link(o_link),
        .o_ras_pred(o_ras_pred), .o_ras_hit(o_ras_hit)
    );

    // Reference model: applies the architectural rules to the inputs seen at an edge.
    task automatic model_step();
        logic [31:0] tgt, lnk, pred;
        logic        tkn, hit;
        if (rst || flush) begin
            {e_valid, e_taken, e_hit} = '0;
            {e_target, e_link, e_pred} = '0;
            if (rst) ras_m.delete();
        end else if (!stall) begin
            tgt = 0; lnk = 0; tkn = 0; pred = 0; hit = 0;
            case (mode)
                3'd1, 3'd2: begin tgt = (pc4 & 32'hF000_0000) | (32'(idx) * 4); tkn = 1; end
                3'd3:       begin tgt = pc4 + 32'($signed(imm)) * 4; tkn = cond; end
                3'd4, 3'd5: begin tgt = rs_data; tkn = 1; end
                default: ;
            endcase
            if (mode == 3'd2 || mode == 3'd5) lnk = pc4 + 4;
            if (valid && (mode == 3'd4 || mode == 3'd5) && rs_is_ra && ras_m.size() > 0) begin
                pred = ras_m.pop_back();
                hit  = (pred == rs_data);
            end
            if (valid && (mode == 3'd2 || mode == 3'd5)) begin
                ras_m.push_back(lnk);
                if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
            end
            e_valid = valid; e_taken = tkn; e_target = tgt; e_link = lnk;
            e_pred = pred; e_hit = hit;
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [31:0] p, input logic [25:0] ix,
                         input logic [15:0] im, input logic c, input logic [31:0] rs,
                         input logic ra, input logic v, input logic st, input logic fl,
                         input logic r);
        mode = m; pc4 = p; idx = ix; imm = im; cond = c; rs_data = rs; rs_is_ra = ra;
        valid = v; stall = st; flush = fl; rst = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        drive(3'd2, 32'h40, 26'h1, 16'h1, 1, 32'h44, 1, 1, 1, 1, 1);
        n_tests++;
        if ({o_valid, o_taken, o_ras_hit} !== 3'b000 || o_target !== 0 || o_link !== 0 || o_ras_pred !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b t=%b h=%b tgt=%h lnk=%h pred=%h want all 0",
                     o_valid, o_taken, o_ras_hit, o_target, o_link, o_ras_pred);
        end
    endtask

    task automatic test_jump();
        drive(3'd1, 32'h1000_0004, 26'h100, 0, 0, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (o_target !== 32'h1000_0400 || o_taken !== 1'b1 || o_valid !== 1'b1 || o_link !== 0) begin
            n_fail++;
            $display("FAIL j_target got tgt=%h t=%b v=%b lnk=%h want 10000400/1/1/0", o_target, o_taken, o_valid, o_link);
        end
        idle();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid got %b want 0", o_valid);
        end
    endtask

    task automatic test_branch();
        drive(3'd3, 32'h100, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (o_target !== 32'h0000_00FC || o_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_taken got tgt=%h t=%b want 000000fc/1", o_target, o_taken);
        end
        drive(3'd3, 32'h100, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (o_target !== 32'h0000_00FC || o_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_not_taken got tgt=%h t=%b want 000000fc/0", o_target, o_taken);
        end
        drive(3'd3, 32'hFFFF_FFF0, 0, 16'h0008, 1, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (o_target !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL br_wrap got %h want 00000010", o_target);
        end
    endtask

    task automatic test_jal_jr();
        do_reset();
        drive(3'd2, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (o_link !== 32'h44 || o_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_link got lnk=%h t=%b want 44/1", o_link, o_taken);
        end
        drive(3'd4, 0, 0, 0, 0, 32'h44, 1, 1, 0, 0, 0);
        n_tests++;
        if (o_ras_pred !== 32'h44 || o_ras_hit !== 1'b1 || o_target !== 32'h44 || o_link !== 0) begin
            n_fail++;
            $display("FAIL jr_pop got pred=%h hit=%b tgt=%h lnk=%h want 44/1/44/0", o_ras_pred, o_ras_hit, o_target, o_link);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] want;
        do_reset();
        for (int i = 1; i <= 5; i++) drive(3'd2, 32'(i * 16 - 4), 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 5; i >= 1; i--) begin
            want = (i >= 2) ? 32'(i * 16) : 32'h0;
            drive(3'd4, 0, 0, 0, 0, 32'(i * 16), 1, 1, 0, 0, 0);
            n_tests++;
            if (o_ras_pred !== want || o_ras_hit !== (i >= 2)) begin
                n_fail++;
                $display("FAIL ras_overflow_pop%0d got pred=%h hit=%b want %h/%b", 6 - i, o_ras_pred, o_ras_hit, want, i >= 2);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(3'd2, 32'h40, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        n_tests++;
        if (o_valid !== 1'b0 || o_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_jal got v=%b t=%b want 0/0", o_valid, o_taken);
        end
        drive(3'd4, 0, 0, 0, 0, 32'h44, 1, 1, 0, 0, 0);
        n_tests++;
        if (o_ras_pred !== 0 || o_ras_hit !== 1'b0 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_no_push got pred=%h hit=%b v=%b want 0/0/1", o_ras_pred, o_ras_hit, o_valid);
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        drive(3'd2, 32'h100, 26'h5, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(3'd3, 32'h200, 0, 16'h4, 0, 0, 0, 1, 1, 0, 0);
            n_tests++;
            if (o_valid !== 1'b1 || o_taken !== 1'b1 || o_target !== 32'h14 || o_link !== 32'h104) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b t=%b tgt=%h lnk=%h want 1/1/14/104", i, o_valid, o_taken, o_target, o_link);
            end
        end
        drive(3'd2, 32'h100, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        n_tests++;
        if ({o_valid, o_taken, o_ras_hit} !== 3'b000 || o_target !== 0 || o_link !== 0 || o_ras_pred !== 0) begin
            n_fail++;
            $display("FAIL stall_reset got v=%b t=%b tgt=%h lnk=%h want all 0", o_valid, o_taken, o_target, o_link);
        end
        drive(3'd4, 0, 0, 0, 0, 32'h104, 1, 1, 0, 0, 0);
        n_tests++;
        if (o_ras_pred !== 0 || o_ras_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ras_empty got pred=%h hit=%b want 0/0", o_ras_pred, o_ras_hit);
        end
    endtask

    task automatic test_random();
        logic [31:0] rs;
        for (int n = 0; n < 600; n++) begin
            rs = $urandom();
            if ($urandom_range(0, 1) == 1 && ras_m.size() > 0) rs = ras_m[$];
            drive(3'($urandom_range(0, 7)), $urandom() & 32'hFFFF_FFFC, 26'($urandom()), 16'($urandom()),
                  1'($urandom()), rs, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
            n_tests++;
            if (o_valid !== e_valid) begin
                n_fail++;
                $display("FAIL rand%0d_valid got %b want %b", n, o_valid, e_valid);
            end
            if (e_valid) begin
                n_tests++;
                if (o_taken !== e_taken || o_target !== e_target || o_link !== e_link ||
                    o_ras_pred !== e_pred || o_ras_hit !== e_hit) begin
                    n_fail++;
                    $display("FAIL rand%0d_data got t=%b tgt=%h lnk=%h pred=%h hit=%b want t=%b tgt=%h lnk=%h pred=%h hit=%b",
                             n, o_taken, o_target, o_link, o_ras_pred, o_ras_hit,
                             e_taken, e_target, e_link, e_pred, e_hit);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_jal_jr();
        test_ras_overflow();
        test_flush();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jump_target_ras.md
JUMP_TARGET_RAS -- requirements
Module: jump_target_ras

Interface
REQ-001 SHALL have parameter NBITS, default 32, datapath/PC width.
REQ-002 SHALL have parameter NBITSJUMP, default 26, J-format instruction-index width.
REQ-003 SHALL have parameter NBITSIMM, default 16, branch immediate width.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  operands valid this cycle.
REQ-008 i_stall  input  1  hold all state and outputs.
REQ-009 i_flush  input  1  discard current input; drop output valid.
REQ-010 i_mode  input  3  000 NONE, 001 J, 010 JAL, 011 BR, 100 JR, 101 JALR; 110/111 treated as NONE.
REQ-011 i_pc4  input  NBITS  PC+4 of the control instruction.
REQ-012 i_instr_index  input  NBITSJUMP  J/JAL index field.
REQ-013 i_imm  input  NBITSIMM  branch offset in words, signed.
REQ-014 i_br_cond  input  1  branch condition resolved true.
REQ-015 i_rs_data  input  NBITS  register operand for JR/JALR.
REQ-016 i_rs_is_ra  input  1  rs field equals 31.
REQ-017 o_valid  output  1  registered result valid.
REQ-018 o_taken  output  1  redirect PC to o_target.
REQ-019 o_target  output  NBITS  computed target.
REQ-020 o_link  output  NBITS  link value for JAL/JALR.
REQ-021 o_ras_pred  output  NBITS  RAS top at pop time (0 if empty).
REQ-022 o_ras_hit  output  1  pop from non-empty RAS and o_ras_pred == i_rs_data.

Function
REQ-023 Latency SHALL be exactly 1 cycle: inputs accepted at edge N appear on outputs after edge N.
REQ-024 J/JAL target SHALL be {i_pc4[NBITS-1:NBITSJUMP+2], i_instr_index, 2'b00}.
REQ-025 BR target SHALL be i_pc4 + (sign-extend(i_imm) << 2), modulo 2^NBITS; o_taken = i_br_cond.
REQ-026 JR/JALR target SHALL be i_rs_data unmodified; o_taken = 1.
REQ-027 J/JAL SHALL assert o_taken = 1; NONE SHALL give o_taken = 0, o_target = 0.
REQ-028 o_link SHALL be i_pc4 + 4 modulo 2^NBITS for JAL/JALR, else 0.
REQ-029 An accepted op is i_valid & ~i_stall & ~i_flush; o_valid next cycle = accepted, except under stall.
REQ-030 JAL/JALR accepted SHALL push o_link value onto RAS.
REQ-031 JR/JALR accepted with i_rs_is_ra = 1 SHALL pop RAS; o_ras_pred/o_ras_hit reflect the popped entry.
REQ-032 JALR with i_rs_is_ra = 1 SHALL pop then push in the same cycle (top replaced, count unchanged if non-empty, becomes 1 if empty).
REQ-033 Push when full SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
REQ-034 Pop when empty SHALL leave count at 0, o_ras_pred = 0, o_ras_hit = 0.
REQ-035 Non-pop ops SHALL give o_ras_pred = 0, o_ras_hit = 0.
REQ-036 i_stall = 1 SHALL hold all outputs and RAS unchanged.
REQ-037 i_flush SHALL have priority over i_stall: o_valid = 0, o_taken = 0 next cycle, no RAS update.
REQ-038 Target computation SHALL be independent of o_valid; downstream qualifies with o_valid.

Reset
REQ-039 On i_reset at a clock edge all outputs SHALL be 0, RAS count and pointer 0, entries 0.
REQ-040 i_reset SHALL override i_stall, i_flush and i_valid; an op in flight at reset is discarded.

Structure
REQ-041 Mode encodings (MODE_NONE..MODE_JALR) SHALL reside in the shared mips package.
REQ-042 The RAS SHALL be a sub-module ras_stack (parameters NBITS, RAS_DEPTH; push, pop, top, empty).

Verification
REQ-043 J: pc4=0x1000_0004, index=0x0000100 -> o_target=0x1000_0400, o_taken=1, one cycle later.
REQ-044 BR: pc4=0x0000_0100, imm=0xFFFF, cond=1 -> o_target=0x0000_00FC, o_taken=1; cond=0 -> o_taken=0.
REQ-045 JAL pc4=0x40 then JR rs_is_ra=1 rs_data=0x44 -> o_link=0x44, then o_ras_pred=0x44, o_ras_hit=1.
REQ-046 Five JALs (depth 4), links 0x10,0x20,0x30,0x40,0x50, then five JR $ra pops -> preds 0x50,0x40,0x30,0x20, fifth pred=0, hit=0.
REQ-047 JAL with i_flush=1 -> o_valid=0 next cycle, following JR $ra pop reports hit=0 (empty).
REQ-048 JAL held under i_stall for 3 cycles, then i_reset -> outputs frozen during stall, all 0 after reset, RAS empty.
